// File: rtl/rom_word_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_word_loader_pkg
//  Purpose  : Shared types and constants for the ROM word loader.
//  Revision : 1.0
// ============================================================================
package rom_word_loader_pkg;

   localparam int unsigned C_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_CAP  = 2'd2,
      ST_OUT  = 2'd3
   } loader_state_e;

endpackage : rom_word_loader_pkg
`default_nettype wire

// File: rtl/rom_word_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_word_loader_if
//  Purpose  : Control, ROM byte-read and word-write signals of the loader.
//  Revision : 1.0
// ============================================================================
interface rom_word_loader_if #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16
);
   logic                      start;
   logic [ADDR_W-1:0]         base_addr;
   logic [CNT_W-1:0]          word_count;
   logic                      busy;
   logic                      done;
   logic                      rom_almost_empty;
   logic                      rom_rd_en;
   logic [7:0]                rom_din;
   logic                      wr_valid;
   logic                      wr_ready;
   logic [ADDR_W-1:0]         wr_addr;
   logic [8*WORD_BYTES-1:0]   wr_data;

   // The loader is the master: it requests bytes and issues writes.
   modport master (
      input  start, base_addr, word_count, rom_almost_empty, rom_din, wr_ready,
      output busy, done, rom_rd_en, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output start, base_addr, word_count, rom_almost_empty, rom_din, wr_ready,
      input  busy, done, rom_rd_en, wr_valid, wr_addr, wr_data
   );
endinterface : rom_word_loader_if
`default_nettype wire

// File: rtl/rom_word_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_word_loader
//  Purpose  : Pulls ROM bytes one at a time, packs them little-endian into
//             words and writes them to sequential addresses.
//  Revision : 1.0
// ============================================================================
module rom_word_loader #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   rom_word_loader_if.master  bus
);
   import rom_word_loader_pkg::*;

   localparam int                IDX_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] C_ADDR_STEP = ADDR_W'(WORD_BYTES);

   loader_state_e                state_q;
   logic                         busy_q;
   logic                         done_q;
   logic                         wr_valid_q;
   logic [ADDR_W-1:0]            wr_addr_q;
   logic [8*WORD_BYTES-1:0]      wr_data_q;
   logic [IDX_W-1:0]             byte_idx_q;
   logic [CNT_W-1:0]             remaining_q;
   logic                         rd_en_d;

   // Backend has a single-entry buffer, so a request is only ever raised from
   // REQ; CAP always follows, which keeps rd_en from firing on back-to-back cycles.
   assign rd_en_d = (state_q == ST_REQ) & ~bus.rom_almost_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         byte_idx_q  <= '0;
         remaining_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  wr_addr_q   <= bus.base_addr;
                  remaining_q <= bus.word_count;
                  byte_idx_q  <= '0;
                  if (bus.word_count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               if (rd_en_d) begin
                  state_q <= ST_CAP;
               end
            end

            ST_CAP: begin
               for (int i = 0; i < WORD_BYTES; i++) begin
                  if (byte_idx_q == IDX_W'(i)) begin
                     wr_data_q[i*C_BYTE_W +: C_BYTE_W] <= bus.rom_din;
                  end
               end
               if (byte_idx_q == C_LAST_IDX) begin
                  wr_valid_q <= 1'b1;
                  state_q    <= ST_OUT;
               end else begin
                  byte_idx_q <= byte_idx_q + IDX_W'(1);
                  state_q    <= ST_REQ;
               end
            end

            ST_OUT: begin
               if (bus.wr_ready) begin
                  wr_valid_q  <= 1'b0;
                  wr_addr_q   <= wr_addr_q + C_ADDR_STEP;
                  remaining_q <= remaining_q - CNT_W'(1);
                  byte_idx_q  <= '0;
                  if (remaining_q == CNT_W'(1)) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_REQ;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rom_rd_en = rd_en_d;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;

endmodule : rom_word_loader
`default_nettype wire
